// File: rtl/pl19_pl20_accessory.sv
// pl19_pl20_accessory
//
// Accessory (device) end of the G-15 PL19/PL20 connectors.
//
// The input path serializes device words toward the CPU. The word goes out
// on PL19_INPUT, LSB first, and advances one bit per CPU shift command.
// The output path assembles CPU output bits from PL20 into characters,
// LSB first, and hands them to a device-side consumer.
//
// Ports
//   CLOCK              system clock (rising edge)
//   rst                asynchronous active-high reset
//   PL19_START_INPUT   CPU start-input level; rising edge arms the input path
//   PL19_STOP_INPUT    CPU stop-input level; rising edge aborts the input path
//   PL19_SHIFT_CMD     CPU input-shift level; rising edge advances one bit
//   PL19_INPUT         serial bit to the CPU
//   PL19_READY_IN      a word is loaded and being shifted
//   PL20_OUTPUT        serial bit from the CPU
//   PL20_OUTPUT_SHIFT  CPU output-shift level; rising edge captures one bit
//   PL20_READY_OUT     accessory can accept output bits
//   dev_in_data/valid/ready     device word source (valid/ready handshake)
//   dev_out_data/valid/ready    character sink (valid/ready handshake)
//   in_underrun        sticky: shift command with no word loaded
//   out_overrun        sticky: output shift while PL20_READY_OUT was low
module pl19_pl20_accessory #(
  parameter int IN_BITS  = 29,
  parameter int OUT_BITS = 5
) (
  input  logic                CLOCK,
  input  logic                rst,
  input  logic                PL19_START_INPUT,
  input  logic                PL19_STOP_INPUT,
  input  logic                PL19_SHIFT_CMD,
  output logic                PL19_INPUT,
  output logic                PL19_READY_IN,
  input  logic                PL20_OUTPUT,
  input  logic                PL20_OUTPUT_SHIFT,
  output logic                PL20_READY_OUT,
  input  logic [IN_BITS-1:0]  dev_in_data,
  input  logic                dev_in_valid,
  output logic                dev_in_ready,
  output logic [OUT_BITS-1:0] dev_out_data,
  output logic                dev_out_valid,
  input  logic                dev_out_ready,
  output logic                in_underrun,
  output logic                out_overrun
);

  localparam int ICW = $clog2(IN_BITS + 1);
  localparam int OCW = $clog2(OUT_BITS + 1);
  localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_BITS - 1);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_BITS - 1);

  typedef enum logic [1:0] {
    IN_IDLE  = 2'd0,
    IN_WAIT  = 2'd1,
    IN_SHIFT = 2'd2
  } in_state_t;

  in_state_t in_state, in_state_nxt;

  logic                start_prev, stop_prev, shift_prev, oshift_prev;
  logic                start_edge, stop_edge, shift_edge, oshift_edge;
  logic                in_load, in_shift;
  logic [IN_BITS-1:0]  in_sr;
  logic [ICW-1:0]      bit_cnt;

  logic [OUT_BITS-1:0] out_sr;
  logic [OUT_BITS:0]   out_cat;
  logic [OUT_BITS-1:0] out_next;
  logic [OCW-1:0]      out_cnt;
  logic                out_accept;

  // ---- strobe edge detection ----
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      start_prev  <= 1'b0;
      stop_prev   <= 1'b0;
      shift_prev  <= 1'b0;
      oshift_prev <= 1'b0;
    end else begin
      start_prev  <= PL19_START_INPUT;
      stop_prev   <= PL19_STOP_INPUT;
      shift_prev  <= PL19_SHIFT_CMD;
      oshift_prev <= PL20_OUTPUT_SHIFT;
    end
  end

  assign start_edge  = PL19_START_INPUT  & ~start_prev;
  assign stop_edge   = PL19_STOP_INPUT   & ~stop_prev;
  assign shift_edge  = PL19_SHIFT_CMD    & ~shift_prev;
  assign oshift_edge = PL20_OUTPUT_SHIFT & ~oshift_prev;

  // ---- input path: FSM ----
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) in_state <= IN_IDLE;
    else     in_state <= in_state_nxt;
  end

  // STOP is checked first so it overrides START, SHIFT and a pending load.
  always_comb begin
    in_state_nxt = in_state;
    in_load      = 1'b0;
    in_shift     = 1'b0;
    if (stop_edge) begin
      in_state_nxt = IN_IDLE;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (start_edge) in_state_nxt = IN_WAIT;
        end
        IN_WAIT: begin
          if (dev_in_valid) begin
            in_load      = 1'b1;
            in_state_nxt = IN_SHIFT;
          end
        end
        IN_SHIFT: begin
          if (shift_edge) begin
            in_shift = 1'b1;
            if (bit_cnt == IN_LAST) in_state_nxt = IN_WAIT;
          end
        end
        default: in_state_nxt = IN_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      in_underrun <= 1'b0;
    end else begin
      if (stop_edge || in_load) begin
        bit_cnt <= '0;
      end else if (in_shift) begin
        bit_cnt <= (bit_cnt == IN_LAST) ? '0 : bit_cnt + 1'b1;
      end
      // Setting takes priority when a START and an unserved shift coincide.
      if (start_edge) in_underrun <= 1'b0;
      if (shift_edge && (in_state != IN_SHIFT)) in_underrun <= 1'b1;
    end
  end

  // The word register needs no reset: the output bit is gated by the state.
  always_ff @(posedge CLOCK) begin
    if (in_load)       in_sr <= dev_in_data;
    else if (in_shift) in_sr <= in_sr >> 1;
  end

  assign PL19_READY_IN = (in_state == IN_SHIFT);
  assign dev_in_ready  = (in_state == IN_WAIT);
  assign PL19_INPUT    = (in_state == IN_SHIFT) & in_sr[0];

  // ---- output path ----
  assign PL20_READY_OUT = ~dev_out_valid;
  assign out_accept     = oshift_edge & ~dev_out_valid;
  // New bit enters at the MSB so the first bit received ends up at bit 0.
  assign out_cat        = {PL20_OUTPUT, out_sr};
  assign out_next       = out_cat[OUT_BITS:1];

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      out_cnt       <= '0;
      dev_out_valid <= 1'b0;
      dev_out_data  <= '0;
      out_overrun   <= 1'b0;
    end else begin
      if (dev_out_valid && dev_out_ready) dev_out_valid <= 1'b0;
      // A shift in the handshake cycle still sees READY_OUT low and is dropped.
      if (oshift_edge && dev_out_valid) out_overrun <= 1'b1;
      if (out_accept) begin
        if (out_cnt == OUT_LAST) begin
          dev_out_data  <= out_next;
          dev_out_valid <= 1'b1;
          out_cnt       <= '0;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end
    end
  end

  // Partial characters are discarded by clearing out_cnt; the shift
  // register itself is fully overwritten before it is ever presented.
  always_ff @(posedge CLOCK) begin
    if (out_accept) out_sr <= out_next;
  end

endmodule

// File: tb/tb_pl19_pl20_accessory.sv
// Testbench for pl19_pl20_accessory: scoreboard of expected PL19 bits and
// expected PL20 characters, compared as the DUT presents them.
module tb_pl19_pl20_accessory;
  localparam int IN_BITS  = 29;
  localparam int OUT_BITS = 5;

  logic                CLOCK = 1'b0;
  logic                rst   = 1'b1;
  logic                PL19_START_INPUT  = 1'b0;
  logic                PL19_STOP_INPUT   = 1'b0;
  logic                PL19_SHIFT_CMD    = 1'b0;
  logic                PL19_INPUT;
  logic                PL19_READY_IN;
  logic                PL20_OUTPUT       = 1'b0;
  logic                PL20_OUTPUT_SHIFT = 1'b0;
  logic                PL20_READY_OUT;
  logic [IN_BITS-1:0]  dev_in_data  = '0;
  logic                dev_in_valid = 1'b0;
  logic                dev_in_ready;
  logic [OUT_BITS-1:0] dev_out_data;
  logic                dev_out_valid;
  logic                dev_out_ready = 1'b0;
  logic                in_underrun;
  logic                out_overrun;

  int n_checks = 0;
  int n_errors = 0;
  logic                exp_in_q[$];
  logic [OUT_BITS-1:0] exp_out_q[$];
  logic                rdy_mid;

  pl19_pl20_accessory #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
    .CLOCK             (CLOCK),
    .rst               (rst),
    .PL19_START_INPUT  (PL19_START_INPUT),
    .PL19_STOP_INPUT   (PL19_STOP_INPUT),
    .PL19_SHIFT_CMD    (PL19_SHIFT_CMD),
    .PL19_INPUT        (PL19_INPUT),
    .PL19_READY_IN     (PL19_READY_IN),
    .PL20_OUTPUT       (PL20_OUTPUT),
    .PL20_OUTPUT_SHIFT (PL20_OUTPUT_SHIFT),
    .PL20_READY_OUT    (PL20_READY_OUT),
    .dev_in_data       (dev_in_data),
    .dev_in_valid      (dev_in_valid),
    .dev_in_ready      (dev_in_ready),
    .dev_out_data      (dev_out_data),
    .dev_out_valid     (dev_out_valid),
    .dev_out_ready     (dev_out_ready),
    .in_underrun       (in_underrun),
    .out_overrun       (out_overrun)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [IN_BITS-1:0] w);
    for (int i = 0; i < IN_BITS; i++) exp_in_q.push_back(w[i]);
  endtask

  task automatic load_word(input logic [IN_BITS-1:0] w);
    dev_in_data  = w;
    dev_in_valid = 1'b1;
    push_word(w);
    @(negedge CLOCK);
    dev_in_valid = 1'b0;
  endtask

  // The CPU samples PL19_INPUT just before raising its shift command.
  task automatic pulse_shift(input bit do_chk);
    if (do_chk) begin
      if (exp_in_q.size() == 0) chk("in_q_empty", 32'd1, 32'd0);
      else                      chk("pl19_bit", 32'(PL19_INPUT), 32'(exp_in_q.pop_front()));
    end
    PL19_SHIFT_CMD = 1'b1;
    @(negedge CLOCK);
    PL19_SHIFT_CMD = 1'b0;
    rdy_mid = PL19_READY_IN;
    @(negedge CLOCK);
  endtask

  task automatic pulse_start();
    PL19_START_INPUT = 1'b1;
    @(negedge CLOCK);
    PL19_START_INPUT = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic pulse_stop();
    PL19_STOP_INPUT = 1'b1;
    @(negedge CLOCK);
    PL19_STOP_INPUT = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic out_bit(input logic b);
    PL20_OUTPUT       = b;
    PL20_OUTPUT_SHIFT = 1'b1;
    @(negedge CLOCK);
    PL20_OUTPUT_SHIFT = 1'b0;
    @(negedge CLOCK);
  endtask

  task automatic send_char(input logic [OUT_BITS-1:0] c);
    exp_out_q.push_back(c);
    for (int i = 0; i < OUT_BITS; i++) out_bit(c[i]);
  endtask

  // Character monitor: handshake is judged 1 ns after the falling edge,
  // when the bench has finished driving and before the next rising edge.
  always begin
    @(negedge CLOCK);
    #1;
    if (!rst && dev_out_valid && dev_out_ready) begin
      if (exp_out_q.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
      else                       chk("out_char", 32'(dev_out_data), 32'(exp_out_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge CLOCK);
    // Reset state
    chk("rst_ready_in",  32'(PL19_READY_IN), 32'd0);
    chk("rst_pl19",      32'(PL19_INPUT), 32'd0);
    chk("rst_in_ready",  32'(dev_in_ready), 32'd0);
    chk("rst_ready_out", 32'(PL20_READY_OUT), 32'd1);
    chk("rst_out_valid", 32'(dev_out_valid), 32'd0);
    chk("rst_out_data",  32'(dev_out_data), 32'd0);
    chk("rst_underrun",  32'(in_underrun), 32'd0);
    chk("rst_overrun",   32'(out_overrun), 32'd0);
    rst = 1'b0;
    @(negedge CLOCK);

    // Single word 5: bits 1,0,1,0,...
    pulse_start();
    chk("w1_in_ready", 32'(dev_in_ready), 32'd1);
    chk("w1_idle_rdy", 32'(PL19_READY_IN), 32'd0);
    load_word(29'h0000_0005);
    chk("w1_ready_in", 32'(PL19_READY_IN), 32'd1);
    chk("w1_in_busy",  32'(dev_in_ready), 32'd0);
    for (int i = 0; i < IN_BITS; i++) begin
      pulse_shift(1'b1);
      if (i == IN_BITS - 2) chk("w1_rdy_last", 32'(rdy_mid), 32'd1);
      if (i == IN_BITS - 1) chk("w1_rdy_drop", 32'(rdy_mid), 32'd0);
    end
    chk("w1_done_rdy", 32'(PL19_READY_IN), 32'd0);
    chk("w1_done_inr", 32'(dev_in_ready), 32'd1);

    // START while waiting for a word is ignored
    pulse_start();
    chk("start_ign", 32'(dev_in_ready), 32'd1);

    // Back-to-back words: all ones then all zeros
    dev_in_data  = 29'h1FFF_FFFF;
    dev_in_valid = 1'b1;
    push_word(29'h1FFF_FFFF);
    @(negedge CLOCK);
    dev_in_data = 29'h0;
    push_word(29'h0);
    for (int i = 0; i < 2 * IN_BITS; i++) begin
      pulse_shift(1'b1);
      if (i == IN_BITS - 1) begin
        chk("b2b_gap",    32'(rdy_mid), 32'd0);
        chk("b2b_reload", 32'(PL19_READY_IN), 32'd1);
        dev_in_valid = 1'b0;
      end
    end
    chk("b2b_done", 32'(PL19_READY_IN), 32'd0);

    // STOP mid-word, then underrun, then START clears it
    load_word(29'h0123_4567);
    for (int i = 0; i < 10; i++) pulse_shift(1'b1);
    pulse_stop();
    exp_in_q.delete();
    chk("stop_ready_in", 32'(PL19_READY_IN), 32'd0);
    chk("stop_in_ready", 32'(dev_in_ready), 32'd0);
    chk("stop_pl19",     32'(PL19_INPUT), 32'd0);
    pulse_shift(1'b0);
    chk("underrun_set",  32'(in_underrun), 32'd1);
    chk("underrun_pl19", 32'(PL19_INPUT), 32'd0);
    pulse_start();
    chk("underrun_clr",  32'(in_underrun), 32'd0);
    chk("restart_inr",   32'(dev_in_ready), 32'd1);

    // Output character 1,1,0,0,1 -> 5'b10011, consumer not ready
    dev_out_ready = 1'b0;
    send_char(5'b10011);
    chk("oc_valid",     32'(dev_out_valid), 32'd1);
    chk("oc_ready_out", 32'(PL20_READY_OUT), 32'd0);
    chk("oc_data",      32'(dev_out_data), 32'h13);
    chk("oc_no_ovr",    32'(out_overrun), 32'd0);

    // Overrun: extra bit while a character is pending
    out_bit(1'b0);
    chk("ovr_flag",  32'(out_overrun), 32'd1);
    chk("ovr_data",  32'(dev_out_data), 32'h13);
    chk("ovr_valid", 32'(dev_out_valid), 32'd1);

    dev_out_ready = 1'b1;
    @(negedge CLOCK);
    chk("hs_valid",     32'(dev_out_valid), 32'd0);
    chk("hs_ready_out", 32'(PL20_READY_OUT), 32'd1);
    chk("ovr_sticky",   32'(out_overrun), 32'd1);

    // Second character with consumer always ready
    send_char(5'b01010);
    @(negedge CLOCK);
    chk("oc2_drained", exp_out_q.size(), 32'd0);

    // Async reset mid-shift on both paths
    dev_out_ready = 1'b0;
    load_word(29'h0ABC_DEF1);
    for (int i = 0; i < 5; i++) pulse_shift(1'b1);
    out_bit(1'b1);
    out_bit(1'b1);
    out_bit(1'b1);
    chk("pre_rst_rdy", 32'(PL19_READY_IN), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready_in",  32'(PL19_READY_IN), 32'd0);
    chk("arst_pl19",      32'(PL19_INPUT), 32'd0);
    chk("arst_in_ready",  32'(dev_in_ready), 32'd0);
    chk("arst_ready_out", 32'(PL20_READY_OUT), 32'd1);
    chk("arst_out_valid", 32'(dev_out_valid), 32'd0);
    chk("arst_out_data",  32'(dev_out_data), 32'd0);
    chk("arst_overrun",   32'(out_overrun), 32'd0);
    chk("arst_underrun",  32'(in_underrun), 32'd0);
    @(negedge CLOCK);
    rst = 1'b0;
    exp_in_q.delete();
    @(negedge CLOCK);

    // Fresh traffic after reset
    pulse_start();
    load_word(29'h0ABC_DEF1);
    for (int i = 0; i < IN_BITS; i++) pulse_shift(1'b1);
    chk("post_ready_in", 32'(PL19_READY_IN), 32'd0);
    dev_out_ready = 1'b1;
    send_char(5'b10101);
    @(negedge CLOCK);
    chk("post_out_drained", exp_out_q.size(), 32'd0);
    chk("post_in_drained",  exp_in_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
